// File: rtl/board_io_pkg.sv
// Shared board I/O constants and types for the push-button conditioning path.
// No logic; the key lane bundle and auto-repeat states are shared by the debouncer files.
package board_io_pkg;

    localparam int NUM_BOARD_KEYS      = 8;
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int REPEAT_DELAY_DEF    = 25_000_000;
    localparam int REPEAT_PERIOD_DEF   = 5_000_000;
    localparam int KEY_CNT_W           = $clog2(DEBOUNCE_CYCLES_DEF);

    typedef struct packed {
        logic level;
        logic press;
        logic released;
    } key_lane_t;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_PERIOD
    } rpt_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key lane: 2-FF synchroniser, stability counter, debounced level and press/release pulses.
// Latency: raw edge to level/pulse is 2 + DEBOUNCE_CYCLES clocks; no backpressure, pulses are one cycle.
// KEY_AUTOREPEAT_EN adds a hold timer that re-issues press pulses while the key stays down.
module key_debounce_cell
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      key_raw,
    output key_lane_t lane
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_cfg
        $error("key_debounce_cell: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
    end

    logic [1:0]       sync_ff;
    logic             sync;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             repeat_fire;

    assign sync   = sync_ff[1];
    assign accept = (sync != lane.level) && (count == CNT_LAST);

    // Any bounce back to the accepted level restarts the stability window.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff <= '0;
            count   <= '0;
            lane    <= '0;
        end else begin
            sync_ff       <= {sync_ff[0], key_raw};
            lane.press    <= (accept && sync) || repeat_fire;
            lane.released <= accept && !sync;
            if (sync == lane.level) begin
                count <= '0;
            end else if (accept) begin
                lane.level <= sync;
                count      <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int               HOLD_W      = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

    rpt_state_t        state;
    rpt_state_t        state_next;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RPT_IDLE;
            hold  <= '0;
        end else begin
            state <= state_next;
            hold  <= hold_next;
        end
    end

    // While held the level is 1, so an accept in DELAY/PERIOD is always the release.
    always_comb begin
        state_next  = state;
        hold_next   = hold;
        repeat_fire = 1'b0;
        case (state)
            RPT_IDLE: begin
                if (accept && sync) begin
                    state_next = RPT_DELAY;
                    hold_next  = '0;
                end
            end
            RPT_DELAY, RPT_PERIOD: begin
                if (accept) begin
                    state_next = RPT_IDLE;
                    hold_next  = '0;
                end else if (hold == ((state == RPT_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                    repeat_fire = 1'b1;
                    state_next  = RPT_PERIOD;
                    hold_next   = '0;
                end else begin
                    hold_next = hold + 1'b1;
                end
            end
            default: begin
                state_next = RPT_IDLE;
                hold_next  = '0;
            end
        endcase
    end
`else
    assign repeat_fire = 1'b0;
`endif

endmodule

// File: rtl/key_debouncer.sv
// Conditions NUM_KEYS active-high push-buttons: debounced level, press/release pulses, sticky press flags.
// Latency: 2 + DEBOUNCE_CYCLES clocks raw edge to level/pulse, event_latched one clock after the press pulse.
// No backpressure; event_clear is write-1-to-clear and loses to a simultaneous press. Option: KEY_AUTOREPEAT_EN.
module key_debouncer
    import board_io_pkg::*;
#(
    parameter int NUM_KEYS        = NUM_BOARD_KEYS,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic [NUM_KEYS-1:0] event_clear,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] event_latched
);

    key_lane_t lane [NUM_KEYS];

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
        key_debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .key_raw(key_raw[i]),
            .lane   (lane[i])
        );

        assign key_level[i]   = lane[i].level;
        assign key_press[i]   = lane[i].press;
        assign key_release[i] = lane[i].released;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            event_latched <= '0;
        end else begin
            event_latched <= (event_latched & ~event_clear) | key_press;
        end
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer with DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=6.
// Expected pulses are queued when stimulus is driven and matched against every observed pulse.
module tb_key_debouncer;

    localparam int NK  = 8;
    localparam int DB  = 8;
    localparam int RD  = 20;
    localparam int RP  = 6;
    localparam int LAT = DB + 2;

    typedef struct packed {
        int         cyc;
        logic [7:0] lane;
        logic       rel;
    } pulse_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] key_raw = '0;
    logic [NK-1:0] event_clear = '0;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] event_latched;

    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    pulse_t exp_q[$];

    key_debouncer #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_raw      (key_raw),
        .event_clear  (event_clear),
        .key_level    (key_level),
        .key_press    (key_press),
        .key_release  (key_release),
        .event_latched(event_latched)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (key_level !== '0) begin errors++; $display("FAIL reset_level: got %b, expected 0", key_level); end
        checks++;
        if (key_press !== '0) begin errors++; $display("FAIL reset_press: got %b, expected 0", key_press); end
        checks++;
        if (key_release !== '0) begin errors++; $display("FAIL reset_release: got %b, expected 0", key_release); end
        checks++;
        if (event_latched !== '0) begin errors++; $display("FAIL reset_latched: got %b, expected 0", event_latched); end
        reset = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            for (int i = 0; i < NK; i++) begin
                for (int k = 0; k < 2; k++) begin
                    if ((k == 0) ? key_press[i] : key_release[i]) begin
                        checks++;
                        errors++;
                        $display("FAIL reset_idle_pulse: got lane %0d rel %0d at cycle %0d, expected no pulse", i, k, cyc);
                    end
                end
            end
        end
    endtask

    task automatic test_clean_press();
        int c0 = 0;
        pulse_t obs, ex;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (n == 0) begin
                key_raw[0] = 1'b1;
                c0 = cyc;
                exp_q.push_back('{cyc: c0 + LAT, lane: 8'd0, rel: 1'b0});
                exp_q.push_back('{cyc: c0 + 15 + LAT, lane: 8'd0, rel: 1'b1});
            end
            if (n == 15) key_raw[0] = 1'b0;
            @(negedge clk);
            if (cyc == c0 + LAT - 1) begin
                checks++;
                if (key_level[0] !== 1'b0) begin errors++; $display("FAIL press_level_early: got %b, expected 0", key_level[0]); end
            end
            if (cyc == c0 + LAT) begin
                checks++;
                if (key_level[0] !== 1'b1) begin errors++; $display("FAIL press_level: got %b, expected 1", key_level[0]); end
            end
            if (cyc == c0 + LAT + 1) begin
                checks++;
                if (event_latched[0] !== 1'b1) begin errors++; $display("FAIL press_latched: got %b, expected 1", event_latched[0]); end
            end
            for (int i = 0; i < NK; i++) begin
                for (int k = 0; k < 2; k++) begin
                    if ((k == 0) ? key_press[i] : key_release[i]) begin
                        obs = '{cyc: cyc, lane: 8'(i), rel: k[0]};
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL press_pulse: got lane %0d rel %0d at cycle %0d, expected no pulse", i, k, cyc);
                        end else begin
                            ex = exp_q.pop_front();
                            if (obs !== ex) begin
                                errors++;
                                $display("FAIL press_pulse: got cycle %0d lane %0d rel %0d, expected cycle %0d lane %0d rel %0d", obs.cyc, obs.lane, obs.rel, ex.cyc, ex.lane, ex.rel);
                            end
                        end
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL press_missing: got %0d pulse(s) unseen, expected 0 (first due cycle %0d)", exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic test_bounce();
        int cf = 1 << 30;
        pulse_t obs, ex;
        for (int n = 0; n < 45; n++) begin
            @(posedge clk); #1;
            if (n == 0 || n == 6) key_raw[1] = 1'b1;
            if (n == 3 || n == 9) key_raw[1] = 1'b0;
            if (n == 12) begin
                key_raw[1] = 1'b1;
                cf = cyc;
                exp_q.push_back('{cyc: cf + LAT, lane: 8'd1, rel: 1'b0});
                exp_q.push_back('{cyc: cf + 18 + LAT, lane: 8'd1, rel: 1'b1});
            end
            if (n == 30) key_raw[1] = 1'b0;
            @(negedge clk);
            if (cyc == cf + LAT - 1) begin
                checks++;
                if (key_level[1] !== 1'b0) begin errors++; $display("FAIL bounce_level_early: got %b, expected 0", key_level[1]); end
            end
            if (cyc == cf + LAT) begin
                checks++;
                if (key_level[1] !== 1'b1) begin errors++; $display("FAIL bounce_level: got %b, expected 1", key_level[1]); end
            end
            for (int i = 0; i < NK; i++) begin
                for (int k = 0; k < 2; k++) begin
                    if ((k == 0) ? key_press[i] : key_release[i]) begin
                        obs = '{cyc: cyc, lane: 8'(i), rel: k[0]};
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL bounce_pulse: got lane %0d rel %0d at cycle %0d, expected no pulse", i, k, cyc);
                        end else begin
                            ex = exp_q.pop_front();
                            if (obs !== ex) begin
                                errors++;
                                $display("FAIL bounce_pulse: got cycle %0d lane %0d rel %0d, expected cycle %0d lane %0d rel %0d", obs.cyc, obs.lane, obs.rel, ex.cyc, ex.lane, ex.rel);
                            end
                        end
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bounce_missing: got %0d pulse(s) unseen, expected 0 (first due cycle %0d)", exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic test_clear_race();
        pulse_t obs, ex;
        for (int n = 0; n < 17; n++) begin
            @(posedge clk); #1;
            event_clear[0] = (n == 0 || n == 12 || n == 14);
            if (n == 2) begin
                key_raw[0] = 1'b1;
                exp_q.push_back('{cyc: cyc + LAT, lane: 8'd0, rel: 1'b0});
            end
            @(negedge clk);
            if (n == 1 || n == 15) begin
                checks++;
                if (event_latched[0] !== 1'b0) begin errors++; $display("FAIL clear_latched_n%0d: got %b, expected 0", n, event_latched[0]); end
            end
            if (n == 13 || n == 14) begin
                checks++;
                if (event_latched[0] !== 1'b1) begin errors++; $display("FAIL race_latched_n%0d: got %b, expected 1", n, event_latched[0]); end
            end
            for (int i = 0; i < NK; i++) begin
                for (int k = 0; k < 2; k++) begin
                    if ((k == 0) ? key_press[i] : key_release[i]) begin
                        obs = '{cyc: cyc, lane: 8'(i), rel: k[0]};
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL race_pulse: got lane %0d rel %0d at cycle %0d, expected no pulse", i, k, cyc);
                        end else begin
                            ex = exp_q.pop_front();
                            if (obs !== ex) begin
                                errors++;
                                $display("FAIL race_pulse: got cycle %0d lane %0d rel %0d, expected cycle %0d lane %0d rel %0d", obs.cyc, obs.lane, obs.rel, ex.cyc, ex.lane, ex.rel);
                            end
                        end
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL race_missing: got %0d pulse(s) unseen, expected 0 (first due cycle %0d)", exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic test_release();
        int c0 = 0;
        pulse_t obs, ex;
        for (int n = 0; n < 14; n++) begin
            @(posedge clk); #1;
            if (n == 0) begin
                key_raw[0] = 1'b0;
                c0 = cyc;
                exp_q.push_back('{cyc: c0 + LAT, lane: 8'd0, rel: 1'b1});
            end
            @(negedge clk);
            if (n == LAT - 1) begin
                checks++;
                if (key_level[0] !== 1'b1) begin errors++; $display("FAIL release_level_early: got %b, expected 1", key_level[0]); end
            end
            if (n == LAT) begin
                checks++;
                if (key_level[0] !== 1'b0) begin errors++; $display("FAIL release_level: got %b, expected 0", key_level[0]); end
            end
            for (int i = 0; i < NK; i++) begin
                for (int k = 0; k < 2; k++) begin
                    if ((k == 0) ? key_press[i] : key_release[i]) begin
                        obs = '{cyc: cyc, lane: 8'(i), rel: k[0]};
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL release_pulse: got lane %0d rel %0d at cycle %0d, expected no pulse", i, k, cyc);
                        end else begin
                            ex = exp_q.pop_front();
                            if (obs !== ex) begin
                                errors++;
                                $display("FAIL release_pulse: got cycle %0d lane %0d rel %0d, expected cycle %0d lane %0d rel %0d", obs.cyc, obs.lane, obs.rel, ex.cyc, ex.lane, ex.rel);
                            end
                        end
                    end
                end
            end
        end
        checks++;
        if (event_latched[0] !== 1'b0) begin errors++; $display("FAIL release_latched: got %b, expected 0", event_latched[0]); end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL release_missing: got %0d pulse(s) unseen, expected 0 (first due cycle %0d)", exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_midcount();
        int c0 = 0;
        pulse_t obs, ex;
        for (int n = 0; n < 34; n++) begin
            @(posedge clk); #1;
            if (n == 0) begin
                key_raw[2] = 1'b1;
                key_raw[5] = 1'b1;
                c0 = cyc;
            end
            if (n == 7) reset = 1'b1;
            if (n == 8) begin
                reset = 1'b0;
                exp_q.push_back('{cyc: cyc + LAT, lane: 8'd2, rel: 1'b0});
                exp_q.push_back('{cyc: cyc + LAT, lane: 8'd5, rel: 1'b0});
            end
            if (n == 20) begin
                key_raw[2] = 1'b0;
                key_raw[5] = 1'b0;
                exp_q.push_back('{cyc: cyc + LAT, lane: 8'd2, rel: 1'b1});
                exp_q.push_back('{cyc: cyc + LAT, lane: 8'd5, rel: 1'b1});
            end
            @(negedge clk);
            if (n == 8) begin
                checks++;
                if ({key_level, key_press, key_release, event_latched} !== '0) begin
                    errors++;
                    $display("FAIL midreset_outputs: got level %b press %b release %b latched %b, expected all 0", key_level, key_press, key_release, event_latched);
                end
            end
            if (n == 8 + LAT - 1) begin
                checks++;
                if (key_level[2] !== 1'b0) begin errors++; $display("FAIL midreset_level_early: got %b, expected 0", key_level[2]); end
            end
            for (int i = 0; i < NK; i++) begin
                for (int k = 0; k < 2; k++) begin
                    if ((k == 0) ? key_press[i] : key_release[i]) begin
                        obs = '{cyc: cyc, lane: 8'(i), rel: k[0]};
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL midreset_pulse: got lane %0d rel %0d at cycle %0d, expected no pulse", i, k, cyc);
                        end else begin
                            ex = exp_q.pop_front();
                            if (obs !== ex) begin
                                errors++;
                                $display("FAIL midreset_pulse: got cycle %0d lane %0d rel %0d, expected cycle %0d lane %0d rel %0d", obs.cyc, obs.lane, obs.rel, ex.cyc, ex.lane, ex.rel);
                            end
                        end
                    end
                end
            end
        end
        checks++;
        if (event_latched !== 8'b0010_0100) begin errors++; $display("FAIL midreset_latched: got %b, expected 00100100", event_latched); end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_missing: got %0d pulse(s) unseen, expected 0 (first due cycle %0d)", exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic test_autorepeat();
        int c0 = 0;
        pulse_t obs, ex;
        logic exp_rpt_latch;
`ifdef KEY_AUTOREPEAT_EN
        exp_rpt_latch = 1'b1;
`else
        exp_rpt_latch = 1'b0;
`endif
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            event_clear[3] = (n == 25);
            if (n == 0) begin
                key_raw[3] = 1'b1;
                c0 = cyc;
                exp_q.push_back('{cyc: c0 + LAT, lane: 8'd3, rel: 1'b0});
`ifdef KEY_AUTOREPEAT_EN
                exp_q.push_back('{cyc: c0 + LAT + RD, lane: 8'd3, rel: 1'b0});
                exp_q.push_back('{cyc: c0 + LAT + RD + RP, lane: 8'd3, rel: 1'b0});
                exp_q.push_back('{cyc: c0 + LAT + RD + 2 * RP, lane: 8'd3, rel: 1'b0});
`endif
                exp_q.push_back('{cyc: c0 + 33 + LAT, lane: 8'd3, rel: 1'b1});
            end
            if (n == 33) key_raw[3] = 1'b0;
            @(negedge clk);
            if (n == 29) begin
                checks++;
                if (event_latched[3] !== 1'b0) begin errors++; $display("FAIL repeat_cleared: got %b, expected 0", event_latched[3]); end
            end
            if (n == LAT + RD + 1) begin
                checks++;
                if (event_latched[3] !== exp_rpt_latch) begin errors++; $display("FAIL repeat_latched: got %b, expected %b", event_latched[3], exp_rpt_latch); end
            end
            for (int i = 0; i < NK; i++) begin
                for (int k = 0; k < 2; k++) begin
                    if ((k == 0) ? key_press[i] : key_release[i]) begin
                        obs = '{cyc: cyc, lane: 8'(i), rel: k[0]};
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL repeat_pulse: got lane %0d rel %0d at cycle %0d, expected no pulse", i, k, cyc);
                        end else begin
                            ex = exp_q.pop_front();
                            if (obs !== ex) begin
                                errors++;
                                $display("FAIL repeat_pulse: got cycle %0d lane %0d rel %0d, expected cycle %0d lane %0d rel %0d", obs.cyc, obs.lane, obs.rel, ex.cyc, ex.lane, ex.rel);
                            end
                        end
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL repeat_missing: got %0d pulse(s) unseen, expected 0 (first due cycle %0d)", exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_clear_race();
        test_release();
        test_reset_midcount();
        test_autorepeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
